// File: rtl/msm_bucket_reduce_if.sv
// Curve point type shared by the bucket store, the adder and the reducer,
// plus the bus interface of the bucket-reduce block.
package msm_pkg;

    localparam int unsigned COORD_W = 16;

    // Prime modulus of the coordinate field used by the stand-in group law.
    localparam logic [COORD_W-1:0] FIELD_P = 16'hFFF1;

    typedef struct packed {
        logic               inf;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } curve_point_t;

    localparam curve_point_t INF_POINT = '{inf: 1'b1, x: 16'h0000, y: 16'h0000};

endpackage

// Control handshake and bucket-store read port of the reducer.
interface msm_bucket_reduce_if #(
    parameter int unsigned WINDOW_BITS = 4
);

    logic                     start;
    logic                     bucket_rd_en;
    logic [WINDOW_BITS-1:0]   bucket_rd_addr;
    msm_pkg::curve_point_t    bucket_rd_data;
    logic                     busy;
    logic                     Done;
    msm_pkg::curve_point_t    R;

    modport master (
        input  start,
        input  bucket_rd_data,
        output bucket_rd_en,
        output bucket_rd_addr,
        output busy,
        output Done,
        output R
    );

    modport slave (
        output start,
        output bucket_rd_data,
        input  bucket_rd_en,
        input  bucket_rd_addr,
        input  busy,
        input  Done,
        input  R
    );

endinterface

// File: rtl/msm_bucket_reduce.sv
// Pippenger window reduction: reads buckets B[2^c-1..1] and forms
// W = sum(j * B[j]) with the running-sum method and one point adder.

// Multi-cycle point adder. A one-cycle Reset samples the request; P and Q
// must stay stable until Done, which then holds with R until the next Reset.
module point_add
    import msm_pkg::*;
#(
    parameter int unsigned LATENCY = 4
) (
    input  logic         clk,
    input  logic         Reset,
    input  curve_point_t P,
    input  curve_point_t Q,
    output curve_point_t R,
    output logic         Done
);

    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    logic [CNT_W-1:0]   cnt;
    logic [COORD_W-1:0] x_c;
    logic [COORD_W-1:0] y_c;
    curve_point_t       sum_c;

    function automatic logic [COORD_W-1:0] mod_add(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        logic [COORD_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, FIELD_P}) begin
            s = s - {1'b0, FIELD_P};
        end
        return s[COORD_W-1:0];
    endfunction

    // Group law; a zero coordinate pair collapses to the canonical inf_point.
    always_comb begin
        x_c   = mod_add(P.x, Q.x);
        y_c   = mod_add(P.y, Q.y);
        sum_c = '{inf: 1'b0, x: x_c, y: y_c};
        if (P.inf) begin
            sum_c = Q;
        end else if (Q.inf) begin
            sum_c = P;
        end else if (x_c == '0 && y_c == '0) begin
            sum_c = INF_POINT;
        end
    end

    // Latency counter; the result is latched once and held with Done.
    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt  <= CNT_W'(LATENCY - 1);
            Done <= 1'b0;
        end else if (!Done) begin
            if (cnt == '0) begin
                R    <= sum_c;
                Done <= 1'b1;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

module msm_bucket_reduce
    import msm_pkg::*;
#(
    parameter int unsigned WINDOW_BITS = 4
) (
    input  logic                clk,
    input  logic                Reset,
    msm_bucket_reduce_if.master bus
);

    localparam int unsigned ADD_LATENCY = 4;
    localparam logic [WINDOW_BITS-1:0] J_TOP  = '1;
    localparam logic [WINDOW_BITS-1:0] J_LAST = WINDOW_BITS'(1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        ADD_T,
        ACC_S,
        ADD_S,
        NEXT,
        DONE
    } state_t;

    state_t                 state_q,   state_d;
    logic [WINDOW_BITS-1:0] j_q,       j_d;
    curve_point_t           t_q,       t_d;
    curve_point_t           s_q,       s_d;
    curve_point_t           op_p_q,    op_p_d;
    curve_point_t           op_q_q,    op_q_d;
    logic                   add_rst_q, add_rst_d;
    logic                   rd_en_q,   rd_en_d;
    logic [WINDOW_BITS-1:0] rd_addr_q, rd_addr_d;
    logic                   busy_q,    busy_d;
    logic                   done_q,    done_d;
    curve_point_t           r_q,       r_d;

    curve_point_t           add_r;
    logic                   add_done;
    logic                   add_done_c;
    logic                   last_c;
    curve_point_t           bj_c;

    point_add #(
        .LATENCY (ADD_LATENCY)
    ) u_add (
        .clk   (clk),
        .Reset (add_rst_q),
        .P     (op_p_q),
        .Q     (op_q_q),
        .R     (add_r),
        .Done  (add_done)
    );

    // The adder still shows the previous result while its Reset is high.
    assign add_done_c = add_done && !add_rst_q;
    assign last_c     = (j_q == J_LAST);
    assign bj_c       = bus.bucket_rd_data;

    // Next-state and datapath decisions for the running-sum walk.
    always_comb begin
        state_d   = state_q;
        j_d       = j_q;
        t_d       = t_q;
        s_d       = s_q;
        op_p_d    = op_p_q;
        op_q_d    = op_q_q;
        add_rst_d = 1'b0;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        busy_d    = busy_q;
        done_d    = done_q;
        r_d       = r_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    t_d       = INF_POINT;
                    s_d       = INF_POINT;
                    j_d       = J_TOP;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = J_TOP;
                    state_d   = FETCH;
                end
            end

            FETCH: begin
                state_d = LATCH;
            end

            LATCH: begin
                if (bj_c == INF_POINT) begin
                    state_d = ACC_S;
                end else if (t_q == INF_POINT) begin
                    t_d     = bj_c;
                    state_d = ACC_S;
                end else begin
                    op_p_d    = t_q;
                    op_q_d    = bj_c;
                    add_rst_d = 1'b1;
                    state_d   = ADD_T;
                end
            end

            ADD_T: begin
                if (add_done_c) begin
                    t_d     = add_r;
                    state_d = ACC_S;
                end
            end

            ACC_S: begin
                if (t_q != INF_POINT && s_q != INF_POINT) begin
                    op_p_d    = s_q;
                    op_q_d    = t_q;
                    add_rst_d = 1'b1;
                    state_d   = ADD_S;
                end else begin
                    if (s_q == INF_POINT) begin
                        s_d = t_q;
                    end
                    // Bucket step finished: fetch the next bucket in the same cycle.
                    if (last_c) begin
                        state_d = NEXT;
                    end else begin
                        j_d       = j_q - J_LAST;
                        rd_en_d   = 1'b1;
                        rd_addr_d = j_q - J_LAST;
                        state_d   = FETCH;
                    end
                end
            end

            ADD_S: begin
                if (add_done_c) begin
                    s_d = add_r;
                    if (last_c) begin
                        state_d = NEXT;
                    end else begin
                        j_d       = j_q - J_LAST;
                        rd_en_d   = 1'b1;
                        rd_addr_d = j_q - J_LAST;
                        state_d   = FETCH;
                    end
                end
            end

            NEXT: begin
                r_d     = s_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = DONE;
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; Reset abandons any run in flight.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            j_q       <= '0;
            t_q       <= INF_POINT;
            s_q       <= INF_POINT;
            op_p_q    <= INF_POINT;
            op_q_q    <= INF_POINT;
            add_rst_q <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            r_q       <= INF_POINT;
        end else begin
            state_q   <= state_d;
            j_q       <= j_d;
            t_q       <= t_d;
            s_q       <= s_d;
            op_p_q    <= op_p_d;
            op_q_q    <= op_q_d;
            add_rst_q <= add_rst_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            r_q       <= r_d;
        end
    end

    assign bus.bucket_rd_en   = rd_en_q;
    assign bus.bucket_rd_addr = rd_addr_q;
    assign bus.busy           = busy_q;
    assign bus.Done           = done_q;
    assign bus.R              = r_q;

endmodule

// File: tb/tb_msm_bucket_reduce.sv
// Bench for msm_bucket_reduce: bucket-store responder, window-sum model
// built from scalar multiples, and a per-cycle compare process.
module tb_msm_bucket_reduce;
    import msm_pkg::*;

    localparam int unsigned WB    = 4;
    localparam int unsigned NB    = 16;
    localparam int unsigned P_INT = 32'(FIELD_P);

    localparam curve_point_t G      = '{inf: 1'b0, x: 16'h1234, y: 16'h0777};
    localparam curve_point_t G2     = '{inf: 1'b0, x: 16'h2468, y: 16'h0EEE};
    localparam curve_point_t G11    = '{inf: 1'b0, x: 16'hC83C, y: 16'h521D};
    localparam curve_point_t G15    = '{inf: 1'b0, x: 16'h111B, y: 16'h6FF9};
    localparam curve_point_t G120   = '{inf: 1'b0, x: 16'h88D8, y: 16'h7FF5};
    localparam curve_point_t POISON = '{inf: 1'b0, x: 16'hDEAD, y: 16'hBEEF};

    logic clk = 1'b0;
    logic Reset;

    always #5 clk = ~clk;

    msm_bucket_reduce_if #(.WINDOW_BITS(WB)) bus ();

    msm_bucket_reduce #(.WINDOW_BITS(WB)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int           checks   = 0;
    int           failures = 0;
    int           reads    = 0;
    curve_point_t mem [NB];
    int           exp_addr [$];
    curve_point_t exp_r = INF_POINT;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Group law of the field model: coordinatewise addition mod p.
    function automatic curve_point_t m_add(input curve_point_t a, input curve_point_t b);
        int unsigned sx;
        int unsigned sy;
        if (a.inf) return b;
        if (b.inf) return a;
        sx = (32'(a.x) + 32'(b.x)) % P_INT;
        sy = (32'(a.y) + 32'(b.y)) % P_INT;
        if (sx == 0 && sy == 0) return INF_POINT;
        return '{inf: 1'b0, x: 16'(sx), y: 16'(sy)};
    endfunction

    // Double-and-add scalar multiplication.
    function automatic curve_point_t m_mul(input int unsigned k, input curve_point_t p);
        curve_point_t acc;
        acc = INF_POINT;
        for (int b = 31; b >= 0; b--) begin
            acc = m_add(acc, acc);
            if (k[b]) acc = m_add(acc, p);
        end
        return acc;
    endfunction

    // Window sum taken directly as sum of j * B[j].
    function automatic curve_point_t m_window();
        curve_point_t w;
        w = INF_POINT;
        for (int j = 1; j < NB; j++) begin
            w = m_add(w, m_mul(32'(j), mem[j]));
        end
        return w;
    endfunction

    // Bucket store: data is valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.bucket_rd_en) begin
            bus.bucket_rd_data <= mem[bus.bucket_rd_addr];
            reads              <= reads + 1;
        end else begin
            bus.bucket_rd_data <= POISON;
        end
    end

    // Per-cycle checks: read order and the held result whenever Done is up.
    always @(negedge clk) begin
        if (!Reset) begin
            if (bus.bucket_rd_en) begin
                if (exp_addr.size() == 0) begin
                    chk("unexpected_read", 64'(bus.bucket_rd_addr), 64'hFFFF);
                end else begin
                    chk("rd_addr", 64'(bus.bucket_rd_addr), 64'(exp_addr.pop_front()));
                end
            end
            if (bus.Done) begin
                chk("done_R", 64'(bus.R), 64'(exp_r));
                chk("done_busy", 64'(bus.busy), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < NB; i++) mem[i] = INF_POINT;
    endtask

    task automatic load_reads();
        exp_addr.delete();
        for (int j = NB - 1; j >= 1; j--) exp_addr.push_back(j);
    endtask

    task automatic run_window(input string name, input int lat, input int extra_start_at,
                              input curve_point_t lit);
        curve_point_t model;
        int           n;
        logic         got;
        model = m_window();
        chk({name, "_model"}, 64'(model), 64'(lit));
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_r = model;
        load_reads();
        chk({name, "_busy_start"}, 64'(bus.busy), 64'd1);
        chk({name, "_done_drop"}, 64'(bus.Done), 64'd0);
        n   = 1;
        got = bus.Done;
        while (!got && n < 2000) begin
            if (n == extra_start_at) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            n++;
            got = bus.Done;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end else begin
            if (lat >= 0) chk({name, "_latency"}, 64'(n), 64'(lat));
            chk({name, "_R"}, 64'(bus.R), 64'(lit));
            chk({name, "_reads_left"}, 64'(exp_addr.size()), 64'd0);
        end
        repeat (3) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int pulses;
        int guard;
        int snap;

        Reset     = 1'b1;
        bus.start = 1'b0;
        clear_mem();
        repeat (3) tick();
        Reset = 1'b0;
        chk("rst_done", 64'(bus.Done), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_R", 64'(bus.R), 64'(INF_POINT));
        chk("rst_rd_en", 64'(bus.bucket_rd_en), 64'd0);
        chk("rst_rd_addr", 64'(bus.bucket_rd_addr), 64'd0);
        tick();

        // Pin the model against hand-derived multiples.
        chk("dbl_add_15G", 64'(m_mul(15, G)), 64'(G15));
        chk("dbl_add_2G", 64'(m_mul(2, G)), 64'(G2));

        clear_mem();
        run_window("all_inf", 47, -1, INF_POINT);

        clear_mem();
        mem[1] = G;
        run_window("b1_G", -1, -1, G);

        clear_mem();
        mem[15] = G;
        run_window("b15_15G", -1, -1, G15);

        for (int i = 1; i < NB; i++) mem[i] = G;
        run_window("all_G_120G", -1, -1, G120);

        clear_mem();
        mem[3] = G2;
        mem[5] = G;
        run_window("b3b5_11G", -1, -1, G11);

        // Abort during the running-sum addition of the second bucket.
        for (int i = 1; i < NB; i++) mem[i] = G;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_r = G120;
        load_reads();
        pulses = 0;
        guard  = 0;
        while (pulses < 2 && guard < 500) begin
            tick();
            if (dut.add_rst_q) pulses++;
            guard++;
        end
        chk("abort_reach_add_s", 64'(pulses), 64'd2);
        tick();
        tick();
        Reset = 1'b1;
        exp_addr.delete();
        exp_r = INF_POINT;
        tick();
        Reset = 1'b0;
        snap  = reads;
        chk("abort_done", 64'(bus.Done), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_R", 64'(bus.R), 64'(INF_POINT));
        chk("abort_rd_en", 64'(bus.bucket_rd_en), 64'd0);
        repeat (20) tick();
        chk("abort_no_reads", 64'(reads), 64'(snap));
        run_window("restart_120G", -1, -1, G120);

        // start together with Reset is dropped.
        Reset     = 1'b1;
        bus.start = 1'b1;
        exp_r     = INF_POINT;
        exp_addr.delete();
        tick();
        Reset     = 1'b0;
        bus.start = 1'b0;
        snap      = reads;
        chk("rst_start_busy", 64'(bus.busy), 64'd0);
        chk("rst_start_done", 64'(bus.Done), 64'd0);
        repeat (10) tick();
        chk("rst_start_no_reads", 64'(reads), 64'(snap));

        // A second start while busy must not restart the walk.
        clear_mem();
        mem[3] = G2;
        mem[5] = G;
        run_window("busy_start_11G", -1, 6, G11);

        clear_mem();
        mem[2] = G;
        run_window("after_done_2G", -1, -1, G2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
